conv33_stream_ctrl: RTL
=======================

# conv33_stream_ctrl

Sequencer that streams a square image from a single-port pixel memory through the `conv33` 3×3 convolution datapath and emits the valid (W−2)×(W−2) output pixels on a ready/valid stream. It generates three-row column fetches, the conv `shift_en` pulses and the end-of-row window clears. It also discards the two warm-up columns of each row. It sits between the frame buffer and the output writer, replacing bench-driven sequencing of `conv33`.

## Interface
Parameters:
- `IMG_W`, 252: input image width and height in pixels; must be ≥3.
- `PIXEL_WIDTH`, 8: pixel width.
- `ADDR_W`, 16: memory address width; must satisfy IMG_W² ≤ 2^ADDR_W.
- `CONV_LAT`, 1: cycles from the conv shift edge to a valid `conv_pixel_out`; must be ≥1.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a frame; sampled only in IDLE.
- `mode_in`, in, 2: filter mode (0 pass, 1 sharpen, 2 gaussian, 3 edge); latched at start.
- `busy`, out, 1: high from the cycle after start is accepted until DONE.
- `done`, out, 1: one-cycle pulse after the last output handshake.
- `mem_rd_en`, out, 1: memory read strobe.
- `mem_addr`, out, ADDR_W: memory read address.
- `mem_rdata`, in, PIXEL_WIDTH: read data, valid exactly one cycle after `mem_rd_en`.
- `conv_pix_top`, out, PIXEL_WIDTH: conv window column input, top row.
- `conv_pix_mid`, out, PIXEL_WIDTH: conv window column input, middle row.
- `conv_pix_bot`, out, PIXEL_WIDTH: conv window column input, bottom row.
- `conv_shift_en`, out, 1: conv column shift.
- `conv_clr`, out, 1: active-high conv window clear; the top level inverts it into the conv active-low reset.
- `conv_mode`, out, 2: latched mode.
- `conv_pixel_out`, in, PIXEL_WIDTH: conv result.
- `out_valid`, out, 1: output stream valid.
- `out_ready`, in, 1: output stream ready.
- `out_data`, out, PIXEL_WIDTH: output pixel.
- `out_last`, out, 1: marks the final output pixel of the frame.

## Operation
- State machine states: IDLE, RD_T, RD_M, RD_B, LATCH, SHIFT, WAIT, EMIT, CLEAR, DONE.
- Counters and registers:
  - `row` runs 0..IMG_W−3.
  - `col` runs 0..IMG_W−1.
  - `base` equals row·IMG_W + col. It is maintained incrementally with no multiplier: +1 per column, +1 at row end.
- IDLE: `start` = 1 latches `mode_in` and clears `row`, `col`, `base`. Next state is RD_T.
- RD_T: `mem_rd_en` = 1 with `mem_addr` = `base`.
- RD_M: `mem_rd_en` = 1 with `mem_addr` = `base` + IMG_W; the top pixel is captured into `conv_pix_top`.
- RD_B: `mem_rd_en` = 1 with `mem_addr` = `base` + 2·IMG_W; the mid pixel is captured into `conv_pix_mid`.
- LATCH: the bottom pixel is captured into `conv_pix_bot`; `mem_rd_en` = 0.
- SHIFT: `conv_shift_en` = 1 for exactly one cycle; all `conv_pix_*` are held stable.
- After SHIFT:
  - If `col` < 2, go to the next column (RD_T). No output is produced.
  - If `col` ≥ 2, go to WAIT for CONV_LAT cycles. On the last WAIT cycle, `conv_pixel_out` is registered into `out_data`.
- EMIT: `out_valid` = 1, with `out_data` held stable until `out_valid`·`out_ready`. `conv_shift_en` stays 0 throughout.
- Column advance:
  - If `col` < IMG_W−1: `col`+1, `base`+1, then RD_T.
  - If `col` = IMG_W−1: go to CLEAR.
- CLEAR: `conv_clr` = 1 for exactly one cycle.
  - If `row` = IMG_W−3, go to DONE.
  - Otherwise `row`+1, `col` = 0, `base`+1 (so `base` lands on the next row start), then RD_T.
- DONE: `done` = 1 for one cycle, then IDLE.
- `out_last` = 1 during EMIT when `row` = IMG_W−3 and `col` = IMG_W−1.
- `start` is ignored when not in IDLE.
- `conv_shift_en` and `conv_clr` are never high in the same cycle.
- `mem_rd_en` is never high outside RD_T/RD_M/RD_B.

## Timing
- Reset (asynchronous, any state, including mid-frame):
  - State goes to IDLE immediately.
  - All outputs go to 0: `busy`, `done`, `mem_rd_en`, `mem_addr`, `conv_pix_*`, `conv_shift_en`, `conv_mode`, `out_valid`, `out_data`, `out_last`.
  - `conv_clr` = 1 while `rst` is high, so the window is cleared.
  - A partial frame is abandoned; no `done` pulse.
- Cycle counts per column, with zero backpressure:
  - 5 cycles for `col` < 2.
  - 5 + CONV_LAT + 1 cycles for `col` ≥ 2.
- Cycles per row: 5·IMG_W + (IMG_W−2)·(CONV_LAT+1) + 1.
- Frame length: from `start` accepted to `done` = (IMG_W−2)·row_cycles + 1 (DONE cycle).
  - Example: IMG_W=5, CONV_LAT=1 gives row = 32 cycles and frame = 97 cycles.
- Backpressure: each cycle with `out_ready` = 0 in EMIT adds one cycle. Nothing else changes during the stall; the conv window is frozen.
- Output count per frame: exactly (IMG_W−2)², in raster order.

## Test plan
- Reset: assert `rst` mid-row with IMG_W=5.
  - All outputs read 0 and `conv_clr` = 1.
  - After release, FSM is IDLE.
  - A new `start` produces a full 9-pixel frame.
- Nominal frame: IMG_W=5, CONV_LAT=1, `out_ready` = 1, memory holds the ramp 0..24, mode 0 (pass).
  - 9 outputs, each equal to the window-centre pixel (6,7,8,11,12,13,16,17,18).
  - `out_last` is asserted only on the 9th output.
  - `done` pulses 97 cycles after `start`.
- Address sequence: column 0 of row 1 issues reads 5, 10, 15 in consecutive cycles.
  - `conv_clr` pulses exactly 3 times per frame.
  - `conv_shift_en` pulses exactly 15 times per frame.
- Backpressure: hold `out_ready` = 0 for 4 cycles on the 2nd output.
  - `out_data` is stable and `conv_shift_en` stays 0 during the stall.
  - Frame length becomes 101 cycles.
- Start while busy: pulse `start` with `mode_in` = 3 mid-frame.
  - The pulse is ignored; `conv_mode` stays at the latched value.
  - The output count stays 9.
- Full-size run: IMG_W=252 with a reference hex image, mode 1.
  - 62500 outputs, matching the golden 250×250 hex file.

Source files
------------

// File: rtl/conv33_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv33_stream_ctrl
// Brief    : Streams a square image through the conv33 3x3 datapath and
//            emits the (W-2)x(W-2) valid output pixels on a ready/valid port.
// Revision : 1.0 - initial release
// ============================================================================
module conv33_stream_ctrl #(
  parameter int IMG_W       = 252,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_W      = 16,
  parameter int CONV_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode_in,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic [PIXEL_WIDTH-1:0] conv_pix_top,
  output logic [PIXEL_WIDTH-1:0] conv_pix_mid,
  output logic [PIXEL_WIDTH-1:0] conv_pix_bot,
  output logic                   conv_shift_en,
  output logic                   conv_clr,
  output logic [1:0]             conv_mode,
  input  logic [PIXEL_WIDTH-1:0] conv_pixel_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic                   out_last
);

  localparam int CNT_W  = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int WAIT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  localparam logic [CNT_W-1:0]  C_LAST_COL   = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  C_LAST_ROW   = CNT_W'(IMG_W - 3);
  localparam logic [CNT_W-1:0]  C_WARMUP     = CNT_W'(2);
  localparam logic [ADDR_W-1:0] C_ROW_STRIDE = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] C_TWO_ROWS   = ADDR_W'(2 * IMG_W);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST  = WAIT_W'(CONV_LAT - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD_T  = 4'd1,
    RD_M  = 4'd2,
    RD_B  = 4'd3,
    LATCH = 4'd4,
    SHIFT = 4'd5,
    WAIT  = 4'd6,
    EMIT  = 4'd7,
    CLEAR = 4'd8,
    DONE  = 4'd9
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       row_q, row_d;
  logic [CNT_W-1:0]       col_q, col_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [1:0]             mode_q, mode_d;
  logic [PIXEL_WIDTH-1:0] pix_top_q, pix_top_d;
  logic [PIXEL_WIDTH-1:0] pix_mid_q, pix_mid_d;
  logic [PIXEL_WIDTH-1:0] pix_bot_q, pix_bot_d;
  logic [PIXEL_WIDTH-1:0] data_q, data_d;
  logic                   clr_fsm;
  logic                   adv_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      base_q    <= '0;
      wait_q    <= '0;
      mode_q    <= '0;
      pix_top_q <= '0;
      pix_mid_q <= '0;
      pix_bot_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      base_q    <= base_d;
      wait_q    <= wait_d;
      mode_q    <= mode_d;
      pix_top_q <= pix_top_d;
      pix_mid_q <= pix_mid_d;
      pix_bot_q <= pix_bot_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    base_d        = base_q;
    wait_d        = wait_q;
    mode_d        = mode_q;
    pix_top_d     = pix_top_q;
    pix_mid_d     = pix_mid_q;
    pix_bot_d     = pix_bot_q;
    data_d        = data_q;
    mem_rd_en     = 1'b0;
    mem_addr      = '0;
    conv_shift_en = 1'b0;
    clr_fsm       = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    done          = 1'b0;
    adv_col       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_in;
          row_d   = '0;
          col_d   = '0;
          base_d  = '0;
          state_d = RD_T;
        end
      end
      RD_T: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q;
        state_d   = RD_M;
      end
      // Memory has one cycle of read latency: each read state captures the
      // data requested by the previous one.
      RD_M: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q + C_ROW_STRIDE;
        pix_top_d = mem_rdata;
        state_d   = RD_B;
      end
      RD_B: begin
        mem_rd_en = 1'b1;
        mem_addr  = base_q + C_TWO_ROWS;
        pix_mid_d = mem_rdata;
        state_d   = LATCH;
      end
      LATCH: begin
        pix_bot_d = mem_rdata;
        state_d   = SHIFT;
      end
      SHIFT: begin
        conv_shift_en = 1'b1;
        if (col_q < C_WARMUP) begin
          adv_col = 1'b1;
        end else begin
          wait_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == C_WAIT_LAST) begin
          data_d  = conv_pixel_out;
          state_d = EMIT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = (row_q == C_LAST_ROW) && (col_q == C_LAST_COL);
        if (out_ready) begin
          adv_col = 1'b1;
        end
      end
      CLEAR: begin
        clr_fsm = 1'b1;
        if (row_q == C_LAST_ROW) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          col_d   = '0;
          base_d  = base_q + 1'b1;
          state_d = RD_T;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // base tracks row*IMG_W + col, so a column step is a plain increment.
    if (adv_col) begin
      if (col_q == C_LAST_COL) begin
        state_d = CLEAR;
      end else begin
        col_d   = col_q + 1'b1;
        base_d  = base_q + 1'b1;
        state_d = RD_T;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign conv_clr     = rst | clr_fsm;
  assign conv_mode    = mode_q;
  assign conv_pix_top = pix_top_q;
  assign conv_pix_mid = pix_mid_q;
  assign conv_pix_bot = pix_bot_q;
  assign out_data     = data_q;

endmodule
`default_nettype wire
